booth_datapath: RTL
===================

# booth_datapath

Register/arithmetic datapath of the 8-bit signed variable-shift Booth multiplier. It is driven cycle by cycle by the multiplier control unit's one-hot strobes (`load`, `sum_or_diff`, `shift`, `valid`) and shift amount (`shmnt`). It feeds the live multiplier register `Q` back to that control unit. On completion it captures the 16-bit signed product into an output register and pulses `done`.

## Interface
- `N`, default 8: operand width. Only 8 is supported with the existing control unit, whose `shmnt` is 4 bits and whose counter starts at 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `multiplicand`  in  N  signed operand M; sampled only on a `load` cycle.
- `multiplier`  in  N  signed operand; sampled only on a `load` cycle.
- `load`  in  1  control strobe: initialise the registers.
- `sum_or_diff`  in  1  control strobe: conditional add or subtract.
- `shift`  in  1  control strobe: arithmetic right shift by `shmnt`.
- `valid`  in  1  control level: the multiplication is finished.
- `shmnt`  in  4  shift amount, used only on `shift` cycles.
- `Q`  out  N  current multiplier register, sent to the control unit.
- `product`  out  2N  registered signed product.
- `done`  out  1  one-cycle pulse when `product` is updated.

## Operation
- State registers:
  - `A`, N+1 bits signed. The extra bit absorbs A−M overflow when M = −128.
  - `Qr`, N bits, driven directly onto `Q`.
  - `q_m1`, 1 bit (Q₋₁).
  - `M`, N bits.
  - `valid_d`, 1 bit.
  - `product`, 2N bits.
  - `done`, 1 bit.
- Strobe priority when several are high (illegal, but the outcome is defined): `load` > `sum_or_diff` > `shift`. `valid` is evaluated independently of the other strobes.
- `load`: A←0, Qr←`multiplier`, q_m1←0, M←`multiplicand`.
- `sum_or_diff`: the action is selected by {Qr[0], q_m1}.
  - 2'b10: A←A−sext(M).
  - 2'b01: A←A+sext(M).
  - 2'b00 or 2'b11: hold.
  - All arithmetic is N+1-bit two's complement with wrap-around. No saturation.
- `shift`: {A,Qr,q_m1} (2N+2 bits) is arithmetically right-shifted by k, sign-filled from A[N].
  - k = `shmnt` for values 0..8.
  - `shmnt` values 9..15 saturate to k = 8.
  - k = 0 holds all registers.
- Result: the product is {A[N-1:0],Qr} as 2N-bit signed. It is exact for all operand pairs, including −128×−128 = 0x4000.
- No strobe high: all of A, Qr, q_m1 and M hold.

## Timing
- Reset (`rst_n`=0 at a clock edge): every register clears to 0, so `Q`=0, `product`=0 and `done`=0. Reset overrides every strobe.
- Reset mid-operation: the registers clear and the datapath stays idle until the next `load`. A later `valid` edge still captures the current {A,Qr}, which is 0 after reset.
- Each strobe takes effect at the rising edge on which it is sampled high. The new `Q` is visible in the next cycle, in time for the control unit's `shmnt` decode.
- Output capture: at the edge where `valid`=1 and `valid_d`=0, `product`←{A[N-1:0],Qr} and `done`←1. At every other edge `done`←0.
  - `done` is therefore high for exactly the one cycle after the first `valid` cycle.
  - `valid_d`←`valid` every cycle.
- `product` holds its value until the next capture or reset. A new `load` does not clear it.
- A level `valid` lasting many cycles produces exactly one `done`.
- Example, multiplier 0xFF: `load`, `sum_or_diff`, `shift`(8), then `valid`. `done` rises 4 cycles after the `load` cycle.

## Structure
- Shared package `booth_pkg`:
  - `N`=8 and the shift-amount width 4.
  - The encodings of the {Qr[0],q_m1} Booth action: `BOOTH_ADD`=2'b01, `BOOTH_SUB`=2'b10.
  - The control unit will import the package in a later cleanup.
- One natural sub-module: `booth_ashr`. It is a combinational 2N+2-bit arithmetic right shifter with 4-bit amount saturation at 8, and can be reused by a future radix-4 variant.
- The top-level multiplier instantiates this block alongside the control unit.

## Test plan
- Reset check. Hold `rst_n`=0 for 2 cycles with random strobes → `Q`=0, `product`=0, `done`=0. Release reset, then run `load` with 3×5 → `Q`=0x05 the next cycle.
- 3×5 with the control unit attached, `start` for one cycle → `product`=0x000F, one `done` pulse, `done` low thereafter while `valid` stays high.
- −7×6, i.e. `multiplicand`=0xF9, `multiplier`=0x06 → `product`=0xFFD6.
- Corner pairs:
  - −128×−128 → 0x4000.
  - 127×−128 → 0xC080.
  - 0×0x5A → 0x0000.
  - 25×0xFF → 0xFFE7, with a single `shift` of 8.
- Isolated datapath with hand-driven strobes:
  - `shift` with `shmnt`=12 → identical to `shmnt`=8.
  - `shmnt`=0 → all registers unchanged.
  - `load` and `shift` high together → the `load` result.
- Reset asserted during a `sum_or_diff` cycle → A=0 and Qr=0 next cycle, no `done`. A subsequent full run of 3×5 yields 0x000F.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared constants for the 8-bit signed variable-shift Booth multiplier.
// Latency: n/a (constants only).
// Backpressure: n/a.
package booth_pkg;

    // Operand width supported by the existing control unit (its counter starts at 8).
    localparam int BOOTH_N   = 8;
    // Width of the shift-amount bus coming from the control unit.
    localparam int SHMNT_W   = 4;
    // Largest shift ever applied; larger shmnt codes saturate to this.
    localparam int SHIFT_MAX = 8;

    // Booth action selected by {Qr[0], q_m1}; 2'b00 and 2'b11 mean hold.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_ashr.sv
// Combinational arithmetic right shifter, amount saturating at MAXK.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module booth_ashr #(
    parameter int W    = 18,
    parameter int SHW  = 4,
    parameter int MAXK = 8
) (
    input  logic [W-1:0]   din,
    input  logic [SHW-1:0] shmnt,
    output logic [W-1:0]   dout
);

    logic [SHW-1:0] k;

    // Clamp the amount, then sign-fill from the MSB of din.
    always_comb begin
        k = shmnt;
        if (shmnt > SHW'(MAXK)) begin
            k = SHW'(MAXK);
        end
        dout = $signed(din) >>> k;
    end

endmodule

// File: rtl/booth_datapath.sv
// Register/arithmetic datapath of the variable-shift Booth multiplier.
// Latency: each strobe acts at the edge it is sampled; product/done one edge after first valid.
// Backpressure: none; strobes are obeyed every cycle, priority load > sum_or_diff > shift.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          multiplicand,
    input  logic [N-1:0]          multiplier,
    input  logic                  load,
    input  logic                  sum_or_diff,
    input  logic                  shift,
    input  logic                  valid,
    input  logic [SHMNT_W-1:0]    shmnt,
    output logic [N-1:0]          Q,
    output logic [2*N-1:0]        product,
    output logic                  done
);

    // A carries one extra bit so that A - M cannot overflow when M is the most negative value.
    logic [N:0]       a_reg;
    logic [N-1:0]     qr;
    logic             q_m1;
    logic [N-1:0]     m_reg;
    logic             valid_d;

    logic [N:0]       m_ext;
    logic [N:0]       a_sum;
    logic [N:0]       a_dif;
    logic [1:0]       booth_pair;
    logic [2*N+1:0]   shift_in;
    logic [2*N+1:0]   shift_out;
    logic             capture;

    // Adder/subtractor operands and the Booth pair that selects between them.
    always_comb begin
        m_ext      = {m_reg[N-1], m_reg};
        a_sum      = a_reg + m_ext;
        a_dif      = a_reg - m_ext;
        booth_pair = {qr[0], q_m1};
        shift_in   = {a_reg, qr, q_m1};
        capture    = valid & ~valid_d;
    end

    booth_ashr #(
        .W    (2*N+2),
        .SHW  (SHMNT_W),
        .MAXK (SHIFT_MAX)
    ) u_ashr (
        .din   (shift_in),
        .shmnt (shmnt),
        .dout  (shift_out)
    );

    // Working registers: initialise on load, accumulate on sum_or_diff, shift the whole {A,Qr,q_m1}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            qr    <= '0;
            q_m1  <= 1'b0;
            m_reg <= '0;
        end else if (load) begin
            a_reg <= '0;
            qr    <= multiplier;
            q_m1  <= 1'b0;
            m_reg <= multiplicand;
        end else if (sum_or_diff) begin
            case (booth_pair)
                BOOTH_SUB: a_reg <= a_dif;
                BOOTH_ADD: a_reg <= a_sum;
                default:   a_reg <= a_reg;
            endcase
        end else if (shift) begin
            {a_reg, qr, q_m1} <= shift_out;
        end
    end

    // Capture the product on the rising edge of valid only, so a held valid gives one done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            valid_d <= valid;
            done    <= capture;
            if (capture) begin
                product <= {a_reg[N-1:0], qr};
            end
        end
    end

    assign Q = qr;

endmodule
